// File: rtl/acc_tile_sequencer.sv
// Per-tile sequencer for the shift-accumulator array. It takes one tile command, gates
// partial-sum beats into the chain, then waits for tile-over before it accepts the next tile.
module acc_tile_sequencer #(
  parameter int SIZE          = 16,
  parameter int K_WIDTH       = 16,
  parameter int CNT_WIDTH     = 16,
  parameter int DRAIN_TIMEOUT = 64,
  localparam int DW = (SIZE > 1) ? $clog2(SIZE) : 1,
  localparam int TW = $clog2(DRAIN_TIMEOUT + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic [K_WIDTH-1:0]   cmd_k_steps_i,
  input  logic [DW-1:0]        cmd_valid_depth_i,
  input  logic                 cmd_init_i,
  input  logic                 beat_valid_i,
  output logic                 beat_ready_o,
  output logic                 acc_input_valid_o,
  output logic                 acc_is_init_data_o,
  output logic                 acc_calc_done_o,
  output logic [DW-1:0]        acc_valid_depth_o,
  input  logic                 acc_tile_over_i,
  output logic                 busy_o,
  output logic                 tile_done_o,
  output logic [CNT_WIDTH-1:0] tiles_done_o,
  output logic                 err_timeout_o
);

  // Handshakes: a command transfers on a rising edge where cmd_valid_i & cmd_ready_o,
  // and a beat transfers on a rising edge where beat_valid_i & beat_ready_o.
  // Ready never depends on valid.
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  state_e               state_q, state_d;
  logic [K_WIDTH-1:0]   k_steps_q, k_steps_d;
  logic [K_WIDTH-1:0]   beat_idx_q, beat_idx_d;
  logic                 init_q, init_d;
  logic [DW-1:0]        depth_q, depth_d;
  logic [TW-1:0]        tmo_q, tmo_d;
  logic                 in_valid_q, in_valid_d;
  logic                 is_init_q, is_init_d;
  logic                 calc_done_q, calc_done_d;
  logic [CNT_WIDTH-1:0] tiles_q, tiles_d;
  logic                 err_q, err_d;
  logic                 last_beat;

  assign last_beat = (beat_idx_q == k_steps_q - 1'b1);

  always_comb begin
    state_d     = state_q;
    k_steps_d   = k_steps_q;
    beat_idx_d  = beat_idx_q;
    init_d      = init_q;
    depth_d     = depth_q;
    tmo_d       = tmo_q;
    in_valid_d  = 1'b0;
    is_init_d   = 1'b0;
    calc_done_d = 1'b0;
    tiles_d     = tiles_q;
    err_d       = err_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          k_steps_d  = cmd_k_steps_i;
          depth_d    = cmd_valid_depth_i;
          init_d     = cmd_init_i;
          beat_idx_d = '0;
          state_d    = (cmd_k_steps_i == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        tmo_d = '0;
        if (beat_valid_i) begin
          in_valid_d  = 1'b1;
          is_init_d   = init_q && (beat_idx_q == '0);
          calc_done_d = last_beat;
          beat_idx_d  = beat_idx_q + 1'b1;
          if (last_beat) state_d = DRAIN;
        end
      end
      DRAIN: begin
        // tile-over takes priority over an expiring timeout in the same cycle
        if (acc_tile_over_i) begin
          state_d = DONE;
        end else if (tmo_q == TW'(DRAIN_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      DONE: begin
        tiles_d = tiles_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      k_steps_q   <= '0;
      beat_idx_q  <= '0;
      init_q      <= 1'b0;
      depth_q     <= '0;
      tmo_q       <= '0;
      in_valid_q  <= 1'b0;
      is_init_q   <= 1'b0;
      calc_done_q <= 1'b0;
      tiles_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_steps_q   <= k_steps_d;
      beat_idx_q  <= beat_idx_d;
      init_q      <= init_d;
      depth_q     <= depth_d;
      tmo_q       <= tmo_d;
      in_valid_q  <= in_valid_d;
      is_init_q   <= is_init_d;
      calc_done_q <= calc_done_d;
      tiles_q     <= tiles_d;
      err_q       <= err_d;
    end
  end

  // Gating ready with rst keeps every output low while reset is held.
  assign cmd_ready_o        = (state_q == IDLE) && !rst;
  assign beat_ready_o       = (state_q == RUN);
  assign busy_o             = (state_q != IDLE);
  assign tile_done_o        = (state_q == DONE);
  assign acc_input_valid_o  = in_valid_q;
  assign acc_is_init_data_o = is_init_q;
  assign acc_calc_done_o    = calc_done_q;
  assign acc_valid_depth_o  = depth_q;
  assign tiles_done_o       = tiles_q;
  assign err_timeout_o      = err_q;

endmodule

// File: tb/tb_acc_tile_sequencer.sv
// Scoreboard bench for acc_tile_sequencer: drivers push expected beats and tile completions,
// and a negedge monitor pops the expectations and compares them with the DUT outputs.
module tb_acc_tile_sequencer;
  localparam int KW = 16;
  localparam int CW = 16;
  localparam int DW = 4;
  localparam int DT = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid_i, cmd_ready_o, cmd_init_i;
  logic [KW-1:0] cmd_k_steps_i;
  logic [DW-1:0] cmd_valid_depth_i;
  logic          beat_valid_i, beat_ready_o;
  logic          acc_input_valid_o, acc_is_init_data_o, acc_calc_done_o;
  logic [DW-1:0] acc_valid_depth_o;
  logic          acc_tile_over_i, busy_o, tile_done_o, err_timeout_o;
  logic [CW-1:0] tiles_done_o;

  acc_tile_sequencer #(.SIZE(16), .K_WIDTH(KW), .CNT_WIDTH(CW), .DRAIN_TIMEOUT(DT)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_k_steps_i(cmd_k_steps_i), .cmd_valid_depth_i(cmd_valid_depth_i), .cmd_init_i(cmd_init_i),
    .beat_valid_i(beat_valid_i), .beat_ready_o(beat_ready_o),
    .acc_input_valid_o(acc_input_valid_o), .acc_is_init_data_o(acc_is_init_data_o),
    .acc_calc_done_o(acc_calc_done_o), .acc_valid_depth_o(acc_valid_depth_o),
    .acc_tile_over_i(acc_tile_over_i), .busy_o(busy_o), .tile_done_o(tile_done_o),
    .tiles_done_o(tiles_done_o), .err_timeout_o(err_timeout_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int            tests = 0;
  int            fails = 0;
  logic [1:0]    exp_q[$];      // {is_init, calc_done} per accepted beat
  logic [CW:0]   tile_q[$];     // {err_flag, tiles_done after increment}
  logic [DW-1:0] depth_model = '0;
  int            tiles_model = 0;
  logic          err_model = 1'b0;
  logic          cnt_pending = 1'b0;
  logic [CW-1:0] cnt_exp = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [1:0]  e;
    logic [CW:0] t;
    if (!rst) begin
      if (cnt_pending) begin
        check("tiles_done", tiles_done_o, cnt_exp);
        cnt_pending = 1'b0;
      end
      check("depth", acc_valid_depth_o, depth_model);
      if (busy_o) check("cmd_ready_busy", cmd_ready_o, 0);
      if (acc_input_valid_o) begin
        if (exp_q.size() == 0) check("unexpected_beat", acc_input_valid_o, 0);
        else begin
          e = exp_q.pop_front();
          check("is_init", acc_is_init_data_o, e[1]);
          check("calc_done", acc_calc_done_o, e[0]);
        end
      end else if (acc_is_init_data_o || acc_calc_done_o) begin
        check("ctrl_without_valid", {acc_is_init_data_o, acc_calc_done_o}, 0);
      end
      if (tile_done_o) begin
        if (tile_q.size() == 0) check("unexpected_tile_done", tile_done_o, 0);
        else begin
          t = tile_q.pop_front();
          check("err_timeout", err_timeout_o, t[CW]);
          cnt_pending = 1'b1;
          cnt_exp = t[CW-1:0];
        end
      end
    end
  end

  // ---------------- driver ----------------
  // mode 0: back-to-back beats, 1: alternating 1,0,1..., 2: random gaps.
  // over_delay 0 withholds tile-over, otherwise it pulses on that drain cycle.
  task automatic run_tile(input int k, input logic [DW-1:0] d, input bit init,
                          input int mode, input int over_delay);
    int w, sent, slot, c, exp_c;
    bit bv, rdy;
    w = 0;
    @(negedge clk);
    while (!cmd_ready_o && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("cmd_ready_wait", cmd_ready_o, 1);
    cmd_valid_i = 1'b1;
    cmd_k_steps_i = KW'(k);
    cmd_valid_depth_i = d;
    cmd_init_i = init;
    for (int i = 0; i < k; i++) exp_q.push_back({init && (i == 0), i == k - 1});
    tiles_model++;
    err_model = err_model | (k != 0 && over_delay == 0);
    tile_q.push_back({err_model, CW'(tiles_model)});
    @(posedge clk);
    depth_model = d;
    #1;
    cmd_valid_i = 1'b0;
    cmd_k_steps_i = KW'($urandom);
    cmd_valid_depth_i = DW'($urandom);
    cmd_init_i = 1'($urandom);
    sent = 0; slot = 0; w = 0;
    while (sent < k && w < 1000) begin
      @(negedge clk);
      case (mode)
        0: bv = 1'b1;
        1: bv = (slot % 2 == 0);
        default: bv = ($urandom_range(0, 2) != 0);
      endcase
      slot++;
      beat_valid_i = bv;
      rdy = beat_ready_o;
      @(posedge clk);
      if (bv && rdy) sent++;
      w++;
    end
    check("beats_sent", sent, k);
    exp_c = (k == 0) ? 1 : ((over_delay == 0) ? DT + 1 : over_delay + 1);
    c = 0;
    while (c < 200) begin
      @(negedge clk);
      c++;
      if (tile_done_o) break;
      acc_tile_over_i = (c == over_delay);
      beat_valid_i = 1'($urandom);  // stray beats outside RUN must not be consumed
    end
    acc_tile_over_i = 1'b0;
    beat_valid_i = 1'b0;
    check("tile_latency", c, exp_c);
    if (mode == 2 && $urandom_range(0, 1) == 1) begin
      @(negedge clk);
      acc_tile_over_i = 1'b1;  // stray tile-over in IDLE is ignored
      beat_valid_i = 1'b1;
      @(negedge clk);
      acc_tile_over_i = 1'b0;
      beat_valid_i = 1'b0;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cmd_ready"}, cmd_ready_o, 0);
    check({tag, "_beat_ready"}, beat_ready_o, 0);
    check({tag, "_acc_ctrl"}, {acc_input_valid_o, acc_is_init_data_o, acc_calc_done_o}, 0);
    check({tag, "_depth"}, acc_valid_depth_o, 0);
    check({tag, "_busy_done"}, {busy_o, tile_done_o}, 0);
    check({tag, "_tiles"}, tiles_done_o, 0);
    check({tag, "_err"}, err_timeout_o, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int sent, w;
    rst = 1'b1;
    cmd_valid_i = 1'b0; cmd_k_steps_i = '0; cmd_valid_depth_i = '0; cmd_init_i = 1'b0;
    beat_valid_i = 1'b0; acc_tile_over_i = 1'b0;
    #1;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    #1 check("ready_after_reset", cmd_ready_o, 1);

    run_tile(4, 4'd5, 1'b1, 0, 3);   // single tile, back-to-back beats
    run_tile(3, 4'd2, 1'b0, 1, 2);   // gapped 1,0,1,0,1
    run_tile(0, 4'd9, 1'b1, 0, 1);   // zero-step tile
    run_tile(2, 4'd4, 1'b1, 0, 0);   // drain timeout
    run_tile(5, 4'd6, 1'b0, 2, 4);   // error flag stays set
    run_tile(3, 4'd3, 1'b1, 0, 1);   // back-to-back depth switch
    run_tile(4, 4'd7, 1'b0, 0, 2);
    for (int i = 0; i < 20; i++) begin
      run_tile($urandom_range(0, 10), DW'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 2,
               ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 6));
    end

    // reset in the middle of an 8-beat tile, after 2 beats
    @(negedge clk);
    w = 0;
    while (!cmd_ready_o && w < 100) begin
      @(negedge clk);
      w++;
    end
    cmd_valid_i = 1'b1; cmd_k_steps_i = 16'd8; cmd_valid_depth_i = 4'd9; cmd_init_i = 1'b1;
    for (int i = 0; i < 8; i++) exp_q.push_back({i == 0, i == 7});
    @(posedge clk);
    depth_model = 4'd9;
    #1 cmd_valid_i = 1'b0;
    sent = 0;
    while (sent < 2) begin
      @(negedge clk);
      beat_valid_i = 1'b1;
      @(posedge clk);
      sent++;
    end
    @(negedge clk);
    #2 rst = 1'b1;
    beat_valid_i = 1'b0;
    #1;
    check_all_zero("mid_reset");
    exp_q.delete(); tile_q.delete();
    tiles_model = 0; err_model = 1'b0; depth_model = '0; cnt_pending = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("ready_after_mid_reset", cmd_ready_o, 1);
    check("tiles_after_mid_reset", tiles_done_o, 0);
    check("busy_after_mid_reset", busy_o, 0);

    run_tile(2, 4'd1, 1'b1, 0, 1);
    repeat (4) @(negedge clk);
    check("beat_queue_drained", exp_q.size(), 0);
    check("tile_queue_drained", tile_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
